// File: rtl/sci_pkg.sv
// Shared SCI definitions: receiver FSM encodings, oversampling constants, register map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // 16 oversample ticks per bit; the start bit is checked at its middle (tick 7),
  // data and stop bits at tick 15 counted from the re-centred start point.
  localparam int         OS_RATIO        = 16;
  localparam logic [3:0] OS_SAMPLE_START = 4'd7;
  localparam logic [3:0] OS_SAMPLE_BIT   = 4'(OS_RATIO - 1);

  // SCI register block offsets (byte addresses)
  localparam logic [7:0] SCI_REG_CTRL   = 8'h00;
  localparam logic [7:0] SCI_REG_STATUS = 8'h04;
  localparam logic [7:0] SCI_REG_BAUD   = 8'h08;
  localparam logic [7:0] SCI_REG_RXDATA = 8'h0C;

endpackage

// File: rtl/sci_rx_fifo.sv
// Show-ahead receive FIFO holding 2**P_FIFO_AW-1 bytes; head is always on o_head_dat.
// Latency: push visible on head/count next cycle; pop exposes the next head next cycle.
// Backpressure: push while full is accepted only if a pop happens in the same cycle, else dropped.
module sci_rx_fifo #(
  parameter int P_FIFO_AW = 4
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 i_clr,
  input  logic                 i_push,
  input  logic [7:0]           i_push_dat,
  input  logic                 i_pop,
  output logic [7:0]           o_head_dat,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [P_FIFO_AW-1:0] o_cnt
);

  localparam int DEPTH = 2 ** P_FIFO_AW;

  logic [7:0]           r_mem [DEPTH];
  logic [P_FIFO_AW-1:0] r_wr_ptr;
  logic [P_FIFO_AW-1:0] r_rd_ptr;
  logic [P_FIFO_AW-1:0] r_cnt;
  logic                 w_pop;
  logic                 w_push;

  // One slot is sacrificed so the count always fits in P_FIFO_AW bits.
  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == {P_FIFO_AW{1'b1}});
  assign o_cnt      = r_cnt;
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_head_dat = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**P_FIFO_AW.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/sci_uart_rx.sv
// SCI UART receiver: 8N1 deserialiser with 16x oversampling feeding a show-ahead byte FIFO.
// Latency: 2-cycle input sync; byte/flags appear the cycle after the stop-bit sample.
// Backpressure: none on the line; a good byte arriving at a full FIFO is dropped with oOVERRUN.
module sci_uart_rx
  import sci_pkg::*;
#(
  parameter int P_DIV_W   = 16,
  parameter int P_FIFO_AW = 4
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 iRX_EN,
  input  logic [P_DIV_W-1:0]   iBAUD_DIV,
  input  logic                 iRX_REQ,
  output logic                 oRX_EMPTY,
  output logic [7:0]           oRX_DATA,
  output logic [P_FIFO_AW-1:0] oRX_BUFF_CNT,
  output logic                 oRX_RECEIVE,
  output logic                 oFRAME_ERR,
  output logic                 oOVERRUN,
  input  logic                 iUART_RXD
);

  logic               r_rxd_s1, r_rxd_s2;
  rx_state_t          r_state, w_state_nxt;
  logic [P_DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]         r_os, w_os_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [7:0]         r_sr, w_sr_nxt;
  logic               r_rx_receive, r_frame_err, r_overrun;
  logic               w_tick, w_push_req, w_frame_err, w_overrun;
  logic               w_fifo_full;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else if (iRESET_SYNC) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= iUART_RXD;
      r_rxd_s2 <= r_rxd_s1;
    end
  end

  assign w_tick = (r_state != ST_IDLE) && (r_div == iBAUD_DIV);

  // Next-state logic: divider, oversample/bit counters, shift register and push/error requests.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = (r_state == ST_IDLE || w_tick) ? '0 : r_div + 1'b1;
    w_os_nxt    = w_tick ? r_os + 4'd1 : r_os;
    w_bit_nxt   = r_bit;
    w_sr_nxt    = r_sr;
    w_push_req  = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_os_nxt = 4'd0;
        if (!r_rxd_s2) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_tick && r_os == OS_SAMPLE_START) begin
          if (r_rxd_s2) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_os_nxt    = 4'd0;
            w_bit_nxt   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (w_tick && r_os == OS_SAMPLE_BIT) begin
          w_sr_nxt = {r_rxd_s2, r_sr[7:1]};
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_tick && r_os == OS_SAMPLE_BIT) begin
          w_push_req  = r_rxd_s2;
          w_frame_err = !r_rxd_s2;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Disabling the receiver abandons any frame in flight.
    if (!iRX_EN) begin
      w_state_nxt = ST_IDLE;
      w_push_req  = 1'b0;
      w_frame_err = 1'b0;
    end
  end

  // A same-cycle pop frees a slot, so only a push into a full FIFO without a pop overruns.
  assign w_overrun = w_push_req && w_fifo_full && !(iRX_REQ && !oRX_EMPTY);

  // Receiver state registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_os    <= 4'd0;
      r_bit   <= 3'd0;
      r_sr    <= 8'h00;
    end else if (iRESET_SYNC) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_os    <= 4'd0;
      r_bit   <= 3'd0;
      r_sr    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_os    <= w_os_nxt;
      r_bit   <= w_bit_nxt;
      r_sr    <= w_sr_nxt;
    end
  end

  // Status pulses, registered so they line up with the FIFO count update.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_rx_receive <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_rx_receive <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_rx_receive <= w_push_req && !w_overrun;
      r_frame_err  <= w_frame_err;
      r_overrun    <= w_overrun;
    end
  end

  assign oRX_RECEIVE = r_rx_receive;
  assign oFRAME_ERR  = r_frame_err;
  assign oOVERRUN    = r_overrun;

  sci_rx_fifo #(
    .P_FIFO_AW (P_FIFO_AW)
  ) u_fifo (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .i_clr      (iRESET_SYNC),
    .i_push     (w_push_req),
    .i_push_dat (r_sr),
    .i_pop      (iRX_REQ),
    .o_head_dat (oRX_DATA),
    .o_empty    (oRX_EMPTY),
    .o_full     (w_fifo_full),
    .o_cnt      (oRX_BUFF_CNT)
  );

endmodule

// File: tb/tb_sci_uart_rx.sv
// Directed bench for sci_uart_rx: frame table plus hand sequences for FIFO and reset corners.
// Latency: one bit = 64 clocks with iBAUD_DIV = 3.
// Backpressure: FIFO pops driven explicitly through iRX_REQ.
module tb_sci_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n, sync_rst, rx_en, rx_req, rxd;
  logic [15:0] baud_div;
  logic       empty, recv, ferr, ovr;
  logic [7:0] data;
  logic [3:0] cnt;

  always #5 clk = ~clk;

  sci_uart_rx #(.P_DIV_W(16), .P_FIFO_AW(4)) dut (
    .iCLOCK       (clk),
    .inRESET      (rst_n),
    .iRESET_SYNC  (sync_rst),
    .iRX_EN       (rx_en),
    .iBAUD_DIV    (baud_div),
    .iRX_REQ      (rx_req),
    .oRX_EMPTY    (empty),
    .oRX_DATA     (data),
    .oRX_BUFF_CNT (cnt),
    .oRX_RECEIVE  (recv),
    .oFRAME_ERR   (ferr),
    .oOVERRUN     (ovr),
    .iUART_RXD    (rxd)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_recv = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int cnt_at_recv = -1;

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (recv) begin
      n_recv++;
      cnt_at_recv = int'(cnt);
    end
    if (ferr) n_ferr++;
    if (ovr)  n_ovr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rxd = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(BIT_CLK);
    end
    rxd = stop_b;
    step(BIT_CLK);
    rxd = 1'b1;
    step(16);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, 32'(data), 32'(exp));
    rx_req = 1'b1;
    step(1);
    rx_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_data"},  32'(data),  32'd0);
    check({tag, "_cnt"},   32'(cnt),   32'd0);
    check({tag, "_recv"},  32'(recv),  32'd0);
    check({tag, "_ferr"},  32'(ferr),  32'd0);
    check({tag, "_ovr"},   32'(ovr),   32'd0);
  endtask

  typedef struct {
    int         kind;      // 0 = frame, 1 = short low glitch
    logic [7:0] b;
    logic       stop_b;
    int         d_recv;
    int         d_ferr;
    int         exp_cnt;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, f0, o0;

    vecs[0] = '{0, 8'hA5, 1'b1, 1, 0, 1, 8'hA5};
    vecs[1] = '{1, 8'h00, 1'b1, 0, 0, 1, 8'hA5};
    vecs[2] = '{0, 8'h3C, 1'b0, 0, 1, 1, 8'hA5};
    vecs[3] = '{0, 8'h5A, 1'b1, 1, 0, 2, 8'hA5};

    rst_n = 1'b0; sync_rst = 1'b0; rx_en = 1'b1; rx_req = 1'b0; rxd = 1'b1; baud_div = 16'd3;
    step(3);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    step(4);
    check_idle_outputs("after_reset");

    // Frame table: good byte, glitch, framing error, second good byte.
    for (int v = 0; v < 4; v++) begin
      r0 = n_recv; f0 = n_ferr; o0 = n_ovr;
      if (vecs[v].kind == 1) begin
        rxd = 1'b0;
        step(20);
        rxd = 1'b1;
        step(80);
      end else begin
        send_frame(vecs[v].b, vecs[v].stop_b);
      end
      check($sformatf("vec%0d_recv", v), 32'(n_recv - r0), 32'(vecs[v].d_recv));
      check($sformatf("vec%0d_ferr", v), 32'(n_ferr - f0), 32'(vecs[v].d_ferr));
      check($sformatf("vec%0d_ovr", v),  32'(n_ovr - o0),  32'd0);
      check($sformatf("vec%0d_cnt", v),  32'(cnt),         32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_head", v), 32'(data),        32'(vecs[v].exp_head));
      check($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].exp_cnt == 0));
      if (vecs[v].d_recv != 0)
        check($sformatf("vec%0d_cnt_with_pulse", v), 32'(cnt_at_recv), 32'(vecs[v].exp_cnt));
    end

    pop_check("pop_a5", 8'hA5);
    pop_check("pop_5a", 8'h5A);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_data", 32'(data), 32'd0);
    rx_req = 1'b1;
    step(1);
    rx_req = 1'b0;
    step(1);
    check("pop_empty_cnt", 32'(cnt), 32'd0);
    check("pop_empty_flag", 32'(empty), 32'd1);

    // Fill past capacity: 15 stored, the 16th overruns.
    r0 = n_recv; o0 = n_ovr;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    check("fill_recv", 32'(n_recv - r0), 32'd15);
    check("fill_ovr", 32'(n_ovr - o0), 32'd1);
    check("fill_cnt", 32'(cnt), 32'd15);
    for (int i = 0; i < 15; i++) pop_check($sformatf("fill_pop%0d", i), 8'(i));
    check("fill_drain_empty", 32'(empty), 32'd1);
    check("fill_drain_cnt", 32'(cnt), 32'd0);

    // Full FIFO with a pop in the push cycle: no overrun, order kept.
    for (int i = 0; i < 15; i++) send_frame(8'(i), 1'b1);
    check("refill_cnt", 32'(cnt), 32'd15);
    r0 = n_recv; o0 = n_ovr;
    fork
      send_frame(8'h77, 1'b1);
      begin
        step(610);
        rx_req = 1'b1;
        step(1);
        rx_req = 1'b0;
      end
    join
    check("pp_recv", 32'(n_recv - r0), 32'd1);
    check("pp_ovr", 32'(n_ovr - o0), 32'd0);
    check("pp_cnt", 32'(cnt), 32'd15);
    check("pp_cnt_with_pulse", 32'(cnt_at_recv), 32'd15);
    for (int i = 1; i < 15; i++) pop_check($sformatf("pp_pop%0d", i), 8'(i));
    pop_check("pp_pop_last", 8'h77);
    check("pp_empty", 32'(empty), 32'd1);

    // Receiver disabled mid-data: partial byte discarded.
    r0 = n_recv; f0 = n_ferr;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        step(200);
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    step(4);
    send_frame(8'h81, 1'b1);
    check("en_recv", 32'(n_recv - r0), 32'd1);
    check("en_ferr", 32'(n_ferr - f0), 32'd0);
    check("en_cnt", 32'(cnt), 32'd1);
    pop_check("en_head", 8'h81);

    // Synchronous reset empties the FIFO.
    send_frame(8'h42, 1'b1);
    check("srst_pre_cnt", 32'(cnt), 32'd1);
    sync_rst = 1'b1;
    step(1);
    sync_rst = 1'b0;
    check_idle_outputs("sync_reset");

    // Asynchronous reset mid-frame, checked between clock edges.
    send_frame(8'h24, 1'b1);
    check("arst_pre_cnt", 32'(cnt), 32'd1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        step(300);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
      end
    join
    rst_n = 1'b1;
    step(4);
    check_idle_outputs("after_async");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
